// File: rtl/mem_arb_pkg.sv
// Shared types for the line-wide memory arbiter.
// FSM state encoding and requester ID constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_AUX    = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection between two line requesters.
// Ports: clk_i/rst_i (pointer state), req0_i/req1_i, grant_i (a grant is
// taken this cycle), win_o (winning ID), any_o (some request pending).
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_i,
    output logic win_o,
    output logic any_o
);

    assign any_o = req0_i | req1_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last-grant pointer; starts at the aux ID so the dcache wins the
    // first tie.
    logic last_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= REQ_AUX;
        end else if (grant_i) begin
            last_q <= win_o;
        end
    end

    always_comb begin
        win_o = REQ_DCACHE;
        if (req0_i && req1_i) begin
            win_o = ~last_q;
        end else if (req1_i) begin
            win_o = REQ_AUX;
        end
    end
`else
    // Fixed priority needs no state.
    logic unused_sig;
    assign unused_sig = &{1'b0, clk_i, rst_i, grant_i};

    always_comb begin
        win_o = REQ_DCACHE;
        if (!req0_i && req1_i) begin
            win_o = REQ_AUX;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared line-wide Data_Memory port.
// Ports: r0_*/r1_* requester side, mem_* memory side, busy_o/owner_o
// status, gnt0/1_cnt_o grant counts, err_o sticky spurious-ack flag.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties, else r0 wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              r0_enable_i,
    input  logic              r0_write_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    output logic              r0_ack_o,
    output logic [DATA_W-1:0] r0_data_o,

    input  logic              r1_enable_i,
    input  logic              r1_write_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    output logic              r1_ack_o,
    output logic [DATA_W-1:0] r1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              busy_o,
    output logic              owner_o,
    output logic [CNT_W-1:0]  gnt0_cnt_o,
    output logic [CNT_W-1:0]  gnt1_cnt_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              owner_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  gnt0_q;
    logic [CNT_W-1:0]  gnt1_q;
    logic              err_q;

    logic              win;
    logic              any_req;
    logic              grant;
    logic              spurious;

    assign grant    = (state_q == IDLE) && any_req;
    assign spurious = (state_q != BUSY) && mem_ack_i;

    mem_arb_picker u_picker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req0_i  (r0_enable_i),
        .req1_i  (r1_enable_i),
        .grant_i (grant),
        .win_o   (win),
        .any_o   (any_req)
    );

    // State register plus the datapath/counter registers it gates.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= REQ_DCACHE;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt0_q  <= '0;
            gnt1_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (grant) begin
                owner_q <= win;
                write_q <= win ? r1_write_i : r0_write_i;
                addr_q  <= win ? r1_addr_i  : r0_addr_i;
                data_q  <= win ? r1_data_i  : r0_data_i;
                // Counters only write while not saturated.
                if (!win && !(&gnt0_q)) begin
                    gnt0_q <= gnt0_q + CNT_ONE;
                end
                if (win && !(&gnt1_q)) begin
                    gnt1_q <= gnt1_q + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (mem_ack_i) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Acks and read data pass straight through in the ack cycle.
    always_comb begin
        mem_enable_o = 1'b0;
        busy_o       = 1'b0;
        r0_ack_o     = 1'b0;
        r1_ack_o     = 1'b0;
        r0_data_o    = '0;
        r1_data_o    = '0;
        unique case (state_q)
            BUSY: begin
                mem_enable_o = 1'b1;
                busy_o       = 1'b1;
                if (mem_ack_i) begin
                    if (owner_q == REQ_AUX) begin
                        r1_ack_o  = 1'b1;
                        r1_data_o = mem_data_i;
                    end else begin
                        r0_ack_o  = 1'b1;
                        r0_data_o = mem_data_i;
                    end
                end
            end
            RELEASE: busy_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    assign mem_write_o = write_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign owner_o     = owner_q;
    assign gnt0_cnt_o  = gnt0_q;
    assign gnt1_cnt_o  = gnt1_q;
    assign err_o       = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 256-bit line-wide Data_Memory port between the data cache refill/write-back path (requester 0) and a second line-wide client (requester 1, instruction-cache refill or DMA). It sits between the CPU-side cache controllers and Data_Memory. It latches the winning request, drives the memory enable/write/addr/data handshake until `mem_ack_i`, then routes the ack and read line back to the owner. Grant counters and a protocol-error flag support performance and debug.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 256: line width.
- `CNT_W`, default 16: grant counter width.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `r0_enable_i`, `r1_enable_i`  in  1  request valid; held until the matching ack.
- `r0_write_i`, `r1_write_i`  in  1  1 = line write, 0 = line read.
- `r0_addr_i`, `r1_addr_i`  in  ADDR_W  line address.
- `r0_data_i`, `r1_data_i`  in  DATA_W  write line.
- `r0_ack_o`, `r1_ack_o`  out  1  one-cycle completion pulse to the owner.
- `r0_data_o`, `r1_data_o`  out  DATA_W  read line; valid while the matching ack is high.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  memory write.
- `mem_addr_o`  out  ADDR_W  latched address.
- `mem_data_o`  out  DATA_W  latched write line.
- `mem_ack_i`  in  1  memory completion pulse.
- `mem_data_i`  in  DATA_W  memory read line.
- `busy_o`  out  1  high in BUSY and RELEASE.
- `owner_o`  out  1  ID of the current or last owner.
- `gnt0_cnt_o`, `gnt1_cnt_o`  out  CNT_W  saturating grant counts.
- `err_o`  out  1  sticky flag for a spurious memory ack.

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- **IDLE**
  - If any enable is high, pick a winner, latch its write/addr/data into the memory-side registers, set `owner_o`, increment that requester's grant counter (saturating at all-ones), and go to BUSY.
  - If no enable is high, stay in IDLE.
- **BUSY**
  - `mem_enable_o` is 1; `mem_write_o`, `mem_addr_o` and `mem_data_o` stay stable.
  - On `mem_ack_i`: `rX_ack_o` for the owner is 1 combinationally in the same cycle, and `rX_data_o` equals `mem_data_i`. Then go to RELEASE.
  - The owner dropping its enable in BUSY is ignored; the transaction completes and is still acked.
- **RELEASE**
  - `mem_enable_o` is 0 for exactly one cycle, giving the owner time to deassert its enable. Then go to IDLE.
- Non-owner requests wait without any limit. Their acks stay 0.
- `mem_ack_i` in IDLE or RELEASE sets `err_o`, which holds until reset. No requester ack is produced.
- `rX_data_o` for the non-owner is 0. Both are 0 when there is no ack.
- Reset, including mid-transaction: state goes to IDLE.
  - All outputs go to 0, with `owner_o` = 0 and the counters and `err_o` cleared.
  - An in-flight memory transaction is abandoned. Its later ack counts as spurious.

## Timing
- The request is sampled at edge N while in IDLE. `mem_enable_o` rises after edge N.
- Requester ack is in the same cycle as `mem_ack_i` (zero added latency).
- Minimum occupancy is 3 cycles per transaction: the grant edge, at least one BUSY cycle, and RELEASE.
- Back-to-back requests from the same or alternating requesters start at the earliest 2 edges after the ack edge.
- Simultaneous requests in IDLE are resolved by the arbitration rule in Configuration, within the same cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin. A last-grant pointer favours the requester that did not win last.
  - The pointer resets to 1, so requester 0 wins the first tie.
- Undefined:
  - Fixed priority; requester 0 always wins ties.
  - Requester 1 can starve. This is acceptable because the dcache stalls the pipeline.

## Structure
- Package `mem_arb_pkg`: the state enum (IDLE, BUSY, RELEASE) and the requester ID constants `REQ_DCACHE` = 0 and `REQ_AUX` = 1.
- Sub-module `mem_arb_picker`:
  - Combinational winner selection from the two enables and the last-grant pointer.
  - Holds the pointer register under `MEM_ARB_ROUND_ROBIN_EN`.

## Test plan
- **Single read.** Stimulus: r0 reads address 0x0000_0020; memory acks 10 cycles later with line 0x8888_9999_…_0000. Required:
  - `r0_ack_o` pulses once, in the ack cycle, with `r0_data_o` equal to that line.
  - `gnt0_cnt_o` = 1.
  - `mem_enable_o` drops for one cycle after the ack.
- **Collision.** Stimulus: r0 writes 0x0200 and r1 reads 0x0400 in the same cycle. Required:
  - With the macro: r0 is served first, then r1; the second `mem_enable_o` rises 2 edges after the first ack.
  - Without the macro: the same order.
- **Fairness.** Stimulus: both requesters continuously re-request for 6 grants. Required:
  - With the macro: grants alternate 0,1,0,1,0,1; the counters end at 3/3.
  - Without the macro: counters are 6/0.
- **Spurious ack.** Stimulus: pulse `mem_ack_i` in IDLE. Required: `err_o` goes to 1 and stays; no requester ack.
- **Reset mid-transaction.** Stimulus: assert `rst_i` low during BUSY. Required:
  - `mem_enable_o` = 0 immediately, without waiting for a clock edge.
  - Counters are 0 and state is IDLE.
  - Re-arbitration starts on the first edge after release.
- **Saturation.** Stimulus: force `gnt0_cnt_o` to 0xFFFF, then grant r0. Required: the count stays 0xFFFF.
